// File: rtl/pcm_arb_pkg.sv
// pcm_arb_pkg
// Shared encodings and widths for the PCM sample-memory arbiter:
// FSM state encoding, requester indices, arbitration policy codes and
// the address/data widths of the PCM read port.

package pcm_arb_pkg;

  localparam int PCM_ADDR_W = 24;
  localparam int PCM_DATA_W = 8;

  localparam int REQ_A = 0;
  localparam int REQ_B = 1;

  localparam int PRIORITY_RR      = 0;
  localparam int PRIORITY_B_FIXED = 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT_A = 2'd1,
    S_GRANT_B = 2'd2
  } arb_state_e;

endpackage

// File: rtl/pcm_arb_watchdog.sv
// pcm_arb_watchdog
// Grant watchdog for pcm_mem_arbiter, only instantiated when PCM_ARB_TIMEOUT_EN
// is defined. Counts grant cycles that pass without a memory completion and
// flags expiry once the count reaches TIMEOUT_CYCLES.
// Ports:
//   clk, reset_n   clock, async active-low reset
//   active_i       a grant is in progress (counter held at 0 otherwise)
//   done_i         memory completion this cycle
//   count_reset_i  synchronous clear of the sticky error
//   expire_o       combinational: the grant has timed out this cycle
//   error_o        sticky timeout flag

module pcm_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic active_i,
  input  logic done_i,
  input  logic count_reset_i,
  output logic expire_o,
  output logic error_o
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  // A real completion in the expiry cycle wins over the forced one.
  assign expire_o = active_i && !done_i && (cnt_q == LIMIT);
  assign error_o  = err_q;

  always_comb begin
    cnt_d = '0;
    err_d = err_q;
    if (active_i && !done_i) begin
      cnt_d = cnt_q + 16'd1;
    end
    if (count_reset_i) begin
      err_d = 1'b0;
    end else if (expire_o) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/pcm_mem_arbiter.sv
// pcm_mem_arbiter
// Shares the single PCM sample-memory read port between the ADPCM-A and
// ADPCM-B readers. One request is selected, its address latched and driven
// to memory until mem_ready; data and ready go back to the owner only.
// Per-requester completion counters are kept for status.
// Ports:
//   clk, reset_n                   clock, async active-low reset
//   a_mem_* / b_mem_*              requester valid/addr in, ready/rdata out
//   mem_valid, mem_addr            memory request out (registered)
//   mem_ready, mem_rdata           memory completion in
//   grant                          one-hot owner, bit0 = A, bit1 = B
//   count_reset                    synchronous clear of counters and error flag
//   a_count, b_count               completed transactions (wrapping)
//   timeout_error                  sticky watchdog flag
// Build option: define PCM_ARB_TIMEOUT_EN to add the grant watchdog
// (pcm_arb_watchdog); otherwise grants wait indefinitely and
// timeout_error is tied 0.
//
// state     | meaning
// S_IDLE    | no owner; any pending request is arbitrated this cycle
// S_GRANT_A | ADPCM-A owns the memory port until mem_ready (or timeout)
// S_GRANT_B | ADPCM-B owns the memory port until mem_ready (or timeout)

module pcm_mem_arbiter
  import pcm_arb_pkg::*;
#(
  parameter int PRIORITY_MODE  = PRIORITY_RR,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  a_mem_valid,
  input  logic [PCM_ADDR_W-1:0] a_mem_addr,
  output logic                  a_mem_ready,
  output logic [PCM_DATA_W-1:0] a_mem_rdata,
  input  logic                  b_mem_valid,
  input  logic [PCM_ADDR_W-1:0] b_mem_addr,
  output logic                  b_mem_ready,
  output logic [PCM_DATA_W-1:0] b_mem_rdata,
  output logic                  mem_valid,
  output logic [PCM_ADDR_W-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic [PCM_DATA_W-1:0] mem_rdata,
  output logic [1:0]            grant,
  input  logic                  count_reset,
  output logic [15:0]           a_count,
  output logic [15:0]           b_count,
  output logic                  timeout_error
);

  arb_state_e            state_q, state_d;
  logic [PCM_ADDR_W-1:0] addr_q, addr_d;
  logic                  last_b_q, last_b_d;  // owner of the last finished grant was B
  logic [15:0]           a_count_q, b_count_q;
  logic                  a_inc, b_inc;
  logic                  pick_b;
  logic                  in_grant;
  logic                  wd_expire;

  assign in_grant = (state_q != S_IDLE);

  // B takes the port when alone, under fixed priority, or on a round-robin
  // tie when A was served last.
  assign pick_b = b_mem_valid &&
                  (!a_mem_valid || (PRIORITY_MODE == PRIORITY_B_FIXED) || !last_b_q);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    last_b_d = last_b_q;
    a_inc    = 1'b0;
    b_inc    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (a_mem_valid || b_mem_valid) begin
          state_d = pick_b ? S_GRANT_B : S_GRANT_A;
          addr_d  = pick_b ? b_mem_addr : a_mem_addr;
        end
      end
      S_GRANT_A: begin
        if (mem_ready || wd_expire) begin
          a_inc    = mem_ready;
          last_b_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      S_GRANT_B: begin
        if (mem_ready || wd_expire) begin
          b_inc    = mem_ready;
          last_b_d = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      last_b_q  <= 1'b0;
      a_count_q <= '0;
      b_count_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      last_b_q <= last_b_d;
      if (count_reset) begin
        a_count_q <= '0;
        b_count_q <= '0;
      end else begin
        if (a_inc) a_count_q <= a_count_q + 16'd1;
        if (b_inc) b_count_q <= b_count_q + 16'd1;
      end
    end
  end

  assign mem_valid = in_grant;
  assign mem_addr  = addr_q;
  assign grant     = {state_q == S_GRANT_B, state_q == S_GRANT_A};
  assign a_count   = a_count_q;
  assign b_count   = b_count_q;

  // A forced (timeout) completion returns zero data.
  assign a_mem_ready = (state_q == S_GRANT_A) && (mem_ready || wd_expire);
  assign b_mem_ready = (state_q == S_GRANT_B) && (mem_ready || wd_expire);
  assign a_mem_rdata = ((state_q == S_GRANT_A) && !wd_expire) ? mem_rdata : '0;
  assign b_mem_rdata = ((state_q == S_GRANT_B) && !wd_expire) ? mem_rdata : '0;

`ifdef PCM_ARB_TIMEOUT_EN
  pcm_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk          (clk),
    .reset_n      (reset_n),
    .active_i     (in_grant),
    .done_i       (mem_ready),
    .count_reset_i(count_reset),
    .expire_o     (wd_expire),
    .error_o      (timeout_error)
  );
`else
  assign wd_expire     = 1'b0;
  assign timeout_error = 1'b0;
`endif

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("pcm_mem_arbiter: TIMEOUT_CYCLES must be within 2..65535");
  end

endmodule

// File: tb/tb_pcm_mem_arbiter.sv
// tb_pcm_mem_arbiter
// Two arbiter instances: index 0 round-robin, index 1 ADPCM-B fixed priority,
// both with TIMEOUT_CYCLES = 8. Expected values come from a transaction-level
// model (pending flags, last owner, completion counts).

module tb_pcm_mem_arbiter;

  logic clk = 1'b0;
  logic reset_n;

  logic [1:0]       a_valid, b_valid, a_ready, b_ready;
  logic [1:0][23:0] a_addr, b_addr, mem_addr;
  logic [1:0][7:0]  a_rdata, b_rdata, mem_rdata;
  logic [1:0]       mem_valid, mem_ready, count_reset, timeout_error;
  logic [1:0][1:0]  grant;
  logic [1:0][15:0] a_count, b_count;

  int n_chk  = 0;
  int n_pass = 0;

  bit          pend_a[2], pend_b[2];
  logic [23:0] cur_a[2], cur_b[2];
  int          m_last[2];              // 0 = A finished last, 1 = B
  logic [15:0] m_acnt[2], m_bcnt[2];

  always #5 clk = ~clk;

  pcm_mem_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(8)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .a_mem_valid(a_valid[0]), .a_mem_addr(a_addr[0]), .a_mem_ready(a_ready[0]), .a_mem_rdata(a_rdata[0]),
    .b_mem_valid(b_valid[0]), .b_mem_addr(b_addr[0]), .b_mem_ready(b_ready[0]), .b_mem_rdata(b_rdata[0]),
    .mem_valid(mem_valid[0]), .mem_addr(mem_addr[0]), .mem_ready(mem_ready[0]), .mem_rdata(mem_rdata[0]),
    .grant(grant[0]), .count_reset(count_reset[0]), .a_count(a_count[0]), .b_count(b_count[0]),
    .timeout_error(timeout_error[0])
  );

  pcm_mem_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(8)) u_fx (
    .clk(clk), .reset_n(reset_n),
    .a_mem_valid(a_valid[1]), .a_mem_addr(a_addr[1]), .a_mem_ready(a_ready[1]), .a_mem_rdata(a_rdata[1]),
    .b_mem_valid(b_valid[1]), .b_mem_addr(b_addr[1]), .b_mem_ready(b_ready[1]), .b_mem_rdata(b_rdata[1]),
    .mem_valid(mem_valid[1]), .mem_addr(mem_addr[1]), .mem_ready(mem_ready[1]), .mem_rdata(mem_rdata[1]),
    .grant(grant[1]), .count_reset(count_reset[1]), .a_count(a_count[1]), .b_count(b_count[1]),
    .timeout_error(timeout_error[1])
  );

  // Arbitration rule: lone requester wins; on a tie instance 1 always
  // serves B, instance 0 serves whoever did not finish last.
  function automatic int pick(int d);
    if (pend_a[d] && !pend_b[d]) return 0;
    if (pend_b[d] && !pend_a[d]) return 1;
    if (d == 1) return 1;
    return (m_last[d] == 0) ? 1 : 0;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      a_valid[d] = 1'b0; b_valid[d] = 1'b0; a_addr[d] = '0; b_addr[d] = '0;
      mem_ready[d] = 1'b0; mem_rdata[d] = '0; count_reset[d] = 1'b0;
      pend_a[d] = 1'b0; pend_b[d] = 1'b0; m_last[d] = 0; m_acnt[d] = '0; m_bcnt[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // One transaction on instance d. Entered just after a rising edge with the
  // DUT idle; leaves just after the completion edge.
  task automatic txn(input int d, input bit ra, input bit rb,
                     input logic [23:0] aa, input logic [23:0] ab, input int lat,
                     input logic [7:0] rd, input bit idle_rdy, input bit clr,
                     output logic [1:0] g_obs);
    int          w;
    logic [23:0] exp_addr;
    logic [1:0]  exp_g;
    logic        wr, lr;
    logic [7:0]  wdat, ldat;
    if (ra && !pend_a[d]) begin pend_a[d] = 1'b1; cur_a[d] = aa; end
    if (rb && !pend_b[d]) begin pend_b[d] = 1'b1; cur_b[d] = ab; end
    a_valid[d] = pend_a[d]; a_addr[d] = cur_a[d];
    b_valid[d] = pend_b[d]; b_addr[d] = cur_b[d];
    mem_ready[d] = idle_rdy; mem_rdata[d] = ~rd;
    w        = pick(d);
    exp_addr = (w == 1) ? cur_b[d] : cur_a[d];
    exp_g    = (w == 1) ? 2'b10 : 2'b01;
    @(negedge clk);
    n_chk++; if (mem_valid[d] !== 1'b0) $display("FAIL idle_mem_valid d=%0d got %b exp 0", d, mem_valid[d]); else n_pass++;
    n_chk++; if (grant[d] !== 2'b00) $display("FAIL idle_grant d=%0d got %b exp 00", d, grant[d]); else n_pass++;
    n_chk++; if ({a_ready[d], b_ready[d]} !== 2'b00) $display("FAIL idle_ready d=%0d got %b exp 00", d, {a_ready[d], b_ready[d]}); else n_pass++;
    n_chk++; if (a_count[d] !== m_acnt[d]) $display("FAIL a_count d=%0d got %h exp %h", d, a_count[d], m_acnt[d]); else n_pass++;
    n_chk++; if (b_count[d] !== m_bcnt[d]) $display("FAIL b_count d=%0d got %h exp %h", d, b_count[d], m_bcnt[d]); else n_pass++;
    @(posedge clk); #1;
    mem_ready[d] = 1'b0;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      n_chk++; if (mem_valid[d] !== 1'b1) $display("FAIL wait_mem_valid d=%0d got %b exp 1", d, mem_valid[d]); else n_pass++;
      n_chk++; if (grant[d] !== exp_g) $display("FAIL wait_grant d=%0d got %b exp %b", d, grant[d], exp_g); else n_pass++;
      n_chk++; if (mem_addr[d] !== exp_addr) $display("FAIL wait_addr d=%0d got %h exp %h", d, mem_addr[d], exp_addr); else n_pass++;
      n_chk++; if ({a_ready[d], b_ready[d]} !== 2'b00) $display("FAIL wait_ready d=%0d got %b exp 00", d, {a_ready[d], b_ready[d]}); else n_pass++;
      @(posedge clk); #1;
    end
    mem_ready[d] = 1'b1; mem_rdata[d] = rd; count_reset[d] = clr;
    @(negedge clk);
    g_obs = grant[d];
    wr   = (w == 1) ? b_ready[d] : a_ready[d];
    wdat = (w == 1) ? b_rdata[d] : a_rdata[d];
    lr   = (w == 1) ? a_ready[d] : b_ready[d];
    ldat = (w == 1) ? a_rdata[d] : b_rdata[d];
    n_chk++; if (grant[d] !== exp_g) $display("FAIL done_grant d=%0d got %b exp %b", d, grant[d], exp_g); else n_pass++;
    n_chk++; if (mem_addr[d] !== exp_addr) $display("FAIL done_addr d=%0d got %h exp %h", d, mem_addr[d], exp_addr); else n_pass++;
    n_chk++; if (wr !== 1'b1) $display("FAIL owner_ready d=%0d got %b exp 1", d, wr); else n_pass++;
    n_chk++; if (wdat !== rd) $display("FAIL owner_rdata d=%0d got %h exp %h", d, wdat, rd); else n_pass++;
    n_chk++; if (lr !== 1'b0) $display("FAIL other_ready d=%0d got %b exp 0", d, lr); else n_pass++;
    n_chk++; if (ldat !== 8'h00) $display("FAIL other_rdata d=%0d got %h exp 00", d, ldat); else n_pass++;
    @(posedge clk); #1;
    mem_ready[d] = 1'b0; count_reset[d] = 1'b0;
    if (w == 1) begin pend_b[d] = 1'b0; b_valid[d] = 1'b0; end
    else begin pend_a[d] = 1'b0; a_valid[d] = 1'b0; end
    if (clr) begin m_acnt[d] = '0; m_bcnt[d] = '0; end
    else if (w == 1) m_bcnt[d] = m_bcnt[d] + 16'd1;
    else m_acnt[d] = m_acnt[d] + 16'd1;
    m_last[d] = w;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_chk++; if (mem_valid[d] !== 1'b0) $display("FAIL rst_mem_valid d=%0d got %b exp 0", d, mem_valid[d]); else n_pass++;
      n_chk++; if (grant[d] !== 2'b00) $display("FAIL rst_grant d=%0d got %b exp 00", d, grant[d]); else n_pass++;
      n_chk++; if (mem_addr[d] !== 24'h0) $display("FAIL rst_mem_addr d=%0d got %h exp 0", d, mem_addr[d]); else n_pass++;
      n_chk++; if ({a_ready[d], b_ready[d]} !== 2'b00) $display("FAIL rst_ready d=%0d got %b exp 00", d, {a_ready[d], b_ready[d]}); else n_pass++;
      n_chk++; if ({a_count[d], b_count[d]} !== 32'h0) $display("FAIL rst_counts d=%0d got %h exp 0", d, {a_count[d], b_count[d]}); else n_pass++;
      n_chk++; if (timeout_error[d] !== 1'b0) $display("FAIL rst_timeout d=%0d got %b exp 0", d, timeout_error[d]); else n_pass++;
    end
  endtask

  task automatic test_single_a();
    logic [1:0] g;
    do_reset();
    txn(0, 1'b1, 1'b0, 24'h012345, 24'h0, 3, 8'hA5, 1'b0, 1'b0, g);
    @(negedge clk);
    n_chk++; if (mem_valid[0] !== 1'b0) $display("FAIL single_release got %b exp 0", mem_valid[0]); else n_pass++;
    n_chk++; if (a_count[0] !== 16'd1) $display("FAIL single_a_count got %h exp 1", a_count[0]); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [1:0] g;
    logic [1:0] order [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      txn(0, 1'b1, 1'b1, 24'h100000 + 24'(i), 24'h200000 + 24'(i), i % 3, 8'(8'h30 + i), 1'b0, 1'b0, g);
      n_chk++; if (g !== order[i]) $display("FAIL rr_order i=%0d got %b exp %b", i, g, order[i]); else n_pass++;
    end
    @(negedge clk);
    n_chk++; if (a_count[0] !== 16'd2) $display("FAIL rr_a_count got %h exp 2", a_count[0]); else n_pass++;
    n_chk++; if (b_count[0] !== 16'd2) $display("FAIL rr_b_count got %h exp 2", b_count[0]); else n_pass++;
  endtask

  task automatic test_fixed_priority();
    logic [1:0] g;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      txn(1, 1'b1, 1'b1, 24'h0A0000 + 24'(i), 24'h0B0000 + 24'(i), 1, 8'(8'h50 + i), 1'b0, 1'b0, g);
      n_chk++; if (g !== 2'b10) $display("FAIL fixed_grant i=%0d got %b exp 10", i, g); else n_pass++;
    end
    @(negedge clk);
    n_chk++; if (a_count[1] !== 16'd0) $display("FAIL fixed_a_count got %h exp 0", a_count[1]); else n_pass++;
    n_chk++; if (b_count[1] !== 16'd3) $display("FAIL fixed_b_count got %h exp 3", b_count[1]); else n_pass++;
  endtask

  task automatic test_random();
    logic [1:0] g;
    do_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 40; i++) begin
        bit ra, rb;
        ra = 1'($urandom_range(0, 1));
        rb = 1'($urandom_range(0, 1));
        if (!pend_a[d] && !pend_b[d] && !ra && !rb) rb = 1'b1;
        txn(d, ra, rb, 24'($urandom), 24'($urandom), int'($urandom_range(0, 3)),
            8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), g);
      end
    end
  endtask

  task automatic test_count_boundaries();
    logic [1:0] g;
    do_reset();
    txn(0, 1'b1, 1'b0, 24'h000111, 24'h0, 0, 8'h11, 1'b0, 1'b0, g);
    txn(0, 1'b0, 1'b1, 24'h0, 24'h000222, 2, 8'h22, 1'b0, 1'b1, g);
    @(negedge clk);
    n_chk++; if (b_count[0] !== 16'd0) $display("FAIL clr_b_count got %h exp 0", b_count[0]); else n_pass++;
    n_chk++; if (a_count[0] !== 16'd0) $display("FAIL clr_a_count got %h exp 0", a_count[0]); else n_pass++;
    @(posedge clk); #1;
    force u_rr.b_count_q = 16'hFFFF;
    #1 release u_rr.b_count_q;
    m_bcnt[0] = 16'hFFFF;
    txn(0, 1'b0, 1'b1, 24'h0, 24'hFFFFFF, 1, 8'hEE, 1'b0, 1'b0, g);
    @(negedge clk);
    n_chk++; if (b_count[0] !== 16'h0000) $display("FAIL wrap_b_count got %h exp 0000", b_count[0]); else n_pass++;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    b_valid[0] = 1'b1; b_addr[0] = 24'h00ABCD;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (grant[0] !== 2'b10) $display("FAIL pre_reset_grant got %b exp 10", grant[0]); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_chk++; if (mem_valid[0] !== 1'b0) $display("FAIL async_mem_valid got %b exp 0", mem_valid[0]); else n_pass++;
    n_chk++; if (grant[0] !== 2'b00) $display("FAIL async_grant got %b exp 00", grant[0]); else n_pass++;
    n_chk++; if (mem_addr[0] !== 24'h0) $display("FAIL async_mem_addr got %h exp 0", mem_addr[0]); else n_pass++;
    do_reset();
  endtask

  task automatic test_timeout();
    do_reset();
    a_valid[0] = 1'b1; a_addr[0] = 24'h0C0FFE; mem_rdata[0] = 8'h5A;
    @(posedge clk); #1;
`ifdef PCM_ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_chk++; if (a_ready[0] !== 1'b0) $display("FAIL to_early_ready i=%0d got %b exp 0", i, a_ready[0]); else n_pass++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_chk++; if (a_ready[0] !== 1'b1) $display("FAIL to_forced_ready got %b exp 1", a_ready[0]); else n_pass++;
    n_chk++; if (a_rdata[0] !== 8'h00) $display("FAIL to_forced_rdata got %h exp 00", a_rdata[0]); else n_pass++;
    @(posedge clk); #1;
    a_valid[0] = 1'b0;
    @(negedge clk);
    n_chk++; if (mem_valid[0] !== 1'b0) $display("FAIL to_mem_valid got %b exp 0", mem_valid[0]); else n_pass++;
    n_chk++; if (timeout_error[0] !== 1'b1) $display("FAIL to_error_set got %b exp 1", timeout_error[0]); else n_pass++;
    n_chk++; if (a_count[0] !== 16'd0) $display("FAIL to_a_count got %h exp 0", a_count[0]); else n_pass++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; if (timeout_error[0] !== 1'b1) $display("FAIL to_error_sticky got %b exp 1", timeout_error[0]); else n_pass++;
    count_reset[0] = 1'b1;
    @(posedge clk); #1;
    count_reset[0] = 1'b0;
    @(negedge clk);
    n_chk++; if (timeout_error[0] !== 1'b0) $display("FAIL to_error_clear got %b exp 0", timeout_error[0]); else n_pass++;
`else
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_chk++; if ({mem_valid[0], a_ready[0], timeout_error[0]} !== 3'b100)
        $display("FAIL no_wd_hold i=%0d got %b exp 100", i, {mem_valid[0], a_ready[0], timeout_error[0]}); else n_pass++;
      @(posedge clk); #1;
    end
    mem_ready[0] = 1'b1; mem_rdata[0] = 8'h3C;
    @(negedge clk);
    n_chk++; if ({a_ready[0], a_rdata[0]} !== 9'h13C) $display("FAIL no_wd_done got %h exp 13c", {a_ready[0], a_rdata[0]}); else n_pass++;
    @(posedge clk); #1;
    mem_ready[0] = 1'b0; a_valid[0] = 1'b0;
    @(negedge clk);
    n_chk++; if (a_count[0] !== 16'd1) $display("FAIL no_wd_a_count got %h exp 1", a_count[0]); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_round_robin();
    test_fixed_priority();
    test_random();
    test_count_boundaries();
    test_reset_mid_grant();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_time_limit got expired exp finished");
    $fatal(1, "time limit");
  end

endmodule
